// File: rtl/lamp_sequencer.sv
// lamp_sequencer: N-lamp thermometer bar walking a three-phase fill/drain pattern, stepped by a prescaler.
// Define LAMP_FLICK_LATCH_EN to turn the synchronised flick levels into sticky rising-edge flags.
module lamp_sequencer #(
   parameter int N       = 16,
   parameter int MID     = 5,
   parameter int PEAK2   = 11,
   parameter int PEAK3   = 6,
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [PRESC_W-1:0] step_div,
   input  logic [1:0]         flick,
   output logic [N-1:0]       lamps,
   output logic [2:0]         state_o,
   output logic               busy,
   output logic               done
);
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] N_C     = CW'(N);
   localparam logic [CW-1:0] MID_C   = CW'(MID);
   localparam logic [CW-1:0] PEAK2_C = CW'(PEAK2);
   localparam logic [CW-1:0] PEAK3_C = CW'(PEAK3);

   typedef enum logic [2:0] {
      IDLE = 3'd0, UP1 = 3'd1, DN1 = 3'd2, UP2 = 3'd3, DN2 = 3'd4, UP3 = 3'd5, DN3 = 3'd6
   } state_t;

   if (N < 2 || N > 64 || MID < 1 || MID >= PEAK3 || PEAK2 <= MID || PEAK2 > N ||
       PEAK3 > N || PRESC_W < 1) begin : g_bad_params
      $error("lamp_sequencer: illegal parameter combination");
   end

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] div_q, div_d;
   logic [1:0]         sync1_q, sync1_d;
   logic [1:0]         fs_q, fs_d;
   logic [1:0]         f;
   logic               tick;
   logic [CW-1:0]      cnt_inc, cnt_dec;

   assign cnt_inc = cnt_q + CW'(1);
   assign cnt_dec = cnt_q - CW'(1);
   // The divisor is captured at reload so a mid-period step_div change cannot skip or stretch a step.
   assign tick    = enable && (presc_q == div_q);

   always_comb begin
      sync1_d = flick;
      fs_d    = sync1_q;
      presc_d = presc_q;
      div_d   = div_q;
      if (tick) begin
         presc_d = '0;
         div_d   = step_div;
      end else if (enable) begin
         presc_d = presc_q + PRESC_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (f[0]) state_d = UP1;
            end
            UP1: begin
               cnt_d = cnt_inc;
               if (cnt_inc == N_C) state_d = DN1;
            end
            DN1: begin
               cnt_d = cnt_dec;
               if (cnt_dec == MID_C) state_d = f[1] ? UP1 : UP2;
            end
            UP2: begin
               cnt_d = cnt_inc;
               if (cnt_inc == PEAK2_C) state_d = DN2;
            end
            DN2: begin
               cnt_d = cnt_dec;
               if (cnt_dec == MID_C && f[1]) state_d = UP2;
               else if (cnt_dec == '0) state_d = f[0] ? UP2 : UP3;
            end
            UP3: begin
               cnt_d = cnt_inc;
               if (cnt_inc == PEAK3_C) state_d = DN3;
            end
            DN3: begin
               cnt_d = cnt_dec;
               if (cnt_dec == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         presc_q <= '0;
         div_q   <= '0;
         sync1_q <= '0;
         fs_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         presc_q <= presc_d;
         div_q   <= div_d;
         sync1_q <= sync1_d;
         fs_q    <= fs_d;
      end
   end

`ifdef LAMP_FLICK_LATCH_EN
   logic [1:0] fs_prev_q, fs_prev_d;
   logic [1:0] lat_q, lat_d;
   logic [1:0] lat_clr;

   assign f = lat_q;

   // A flag is cleared at every decision point that looks at it; a coincident new edge still sets it.
   always_comb begin
      fs_prev_d = fs_q;
      lat_clr   = '0;
      if (tick) begin
         if (state_q == IDLE || (state_q == DN2 && cnt_dec == '0)) lat_clr[0] = 1'b1;
         if ((state_q == DN1 || state_q == DN2) && cnt_dec == MID_C) lat_clr[1] = 1'b1;
      end
      if (done_d) lat_clr = 2'b11;
      lat_d = (lat_q & ~lat_clr) | (fs_q & ~fs_prev_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fs_prev_q <= '0;
         lat_q     <= '0;
      end else begin
         fs_prev_q <= fs_prev_d;
         lat_q     <= lat_d;
      end
   end
`else
   assign f = fs_q;
`endif

   for (genvar gi = 0; gi < N; gi++) begin : g_lamp
      assign lamps[gi] = (cnt_q > CW'(gi));
   end

   assign state_o = state_q;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;
endmodule

// File: doc/lamp_sequencer.md
# lamp_sequencer

Parametrised thermometer-bar lamp sequencer driving an N-lamp strip through a fixed three-phase fill/drain pattern. The `flick` inputs start the pattern and can re-kick it at defined turn points. It adds three things over the fixed 16-lamp sequencer: width and turn-point parameters, a programmable step prescaler, and flick synchronisation. It sits between the board switch inputs and the lamp driver outputs.

## Interface
- `N`, 16: lamp count; legal range 2..64.
- `MID`, 5: turn-back lamp count for DN1 and DN2; legal range 1 ≤ MID < PEAK3.
- `PEAK2`, 11: top of UP2; legal range MID < PEAK2 ≤ N.
- `PEAK3`, 6: top of UP3; legal range MID < PEAK3 ≤ N.
- `PRESC_W`, 8: prescaler width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: step enable; when low, the prescaler, state and lamps all freeze.
- `step_div` in PRESC_W: one step every `step_div+1` enabled cycles.
- `flick` in 2: asynchronous switch inputs. Bit 0 is start/restart; bit 1 is re-kick.
- `lamps` out N: thermometer bar; `lamps[i]=1` iff `i < cnt`.
- `state_o` out 3: current state, encoded IDLE=0, UP1=1, DN1=2, UP2=3, DN2=4, UP3=5, DN3=6.
- `busy` out 1: `state_o != IDLE`.
- `done` out 1: one-cycle pulse on the DN3→IDLE transition.

## Operation
- Internal count `cnt` has width clog2(N+1), range 0..N. `lamps` is derived combinationally from registered `cnt`.
- Each `flick` bit passes through a 2-flop synchroniser. Decisions use the synchronised value `fs`.
- Step tick rule:
  - The prescaler counts enabled cycles from 0 up to `step_div`.
  - The tick fires on the cycle the prescaler equals `step_div`, then the prescaler reloads to 0.
  - A new `step_div` value takes effect at the next reload.
- All state and `cnt` updates happen only on a tick. Per tick:
  - IDLE: `cnt=0`. If `fs[0]`, go to UP1; `cnt` stays 0.
  - UP1: `cnt+1`. When the new `cnt==N`, go to DN1.
  - DN1: `cnt-1`. When the new `cnt==MID`: if `fs[1]`, go to UP1; otherwise go to UP2.
  - UP2: `cnt+1`. When the new `cnt==PEAK2`, go to DN2.
  - DN2: `cnt-1`.
    - When the new `cnt==MID` and `fs[1]`, go to UP2.
    - When the new `cnt==MID` and not `fs[1]`, stay in DN2.
    - When the new `cnt==0`: if `fs[0]`, go to UP2; otherwise go to UP3.
  - UP3: `cnt+1`. When the new `cnt==PEAK3`, go to DN3.
  - DN3: `cnt-1`. When the new `cnt==0`, go to IDLE and pulse `done`.
- There is no dwell at turn points: the tick after reaching a peak already decrements.
- `cnt` never leaves 0..N. Parameter legality is enforced by an elaboration-time check.
- Unused state encoding 7: the next tick forces IDLE with `cnt=0`.

## Timing
- Reset values: `lamps=0`, `state_o=0`, `busy=0`, `done=0`, `cnt=0`, prescaler 0, synchronisers 0, latches 0.
- Reset is asynchronous assert. Deassert is used directly; the upstream reset synchroniser is external.
- Reset mid-pattern returns to IDLE immediately, and `lamps` goes to 0 in the same instant.
- `flick` to `fs` latency is 2 clk.
- `fs` is sampled on the tick cycle, so a pulse shorter than the tick period can be missed (level mode).
- `lamps`, `state_o` and `busy` update on the clock edge ending the tick cycle.
- `done` is high for exactly the one cycle after that edge.
- When `enable` drops, a tick pending on that cycle is suppressed. The prescaler resumes from its held value.

## Configuration
- `LAMP_FLICK_LATCH_EN` defined:
  - A rising edge on `fs[b]` sets sticky flag `lat[b]`. The decisions above use `lat[b]` in place of `fs[b]`.
  - `lat[0]` clears when consumed in IDLE, and when consumed or examined at the DN2 `cnt==0` point.
  - `lat[1]` clears at every `cnt==MID` decision point in DN1 or DN2, whether it was set or not.
  - Both flags clear on entering IDLE from DN3.
  - If an edge coincides with a clear, the set wins.
- `LAMP_FLICK_LATCH_EN` undefined: level sampling of `fs` on the tick. No latch flops are built.

## Test plan
- Defaults, `step_div=0`, `enable=1`, 1-cycle `flick[0]` pulse, `flick[1]=0` → full pattern: 57 ticks from IDLE exit to `done`. Peaks seen: 0xFFFF, then 0x001F, 0x07FF, 0x0000, 0x003F, 0x0000. `done` asserts once.
- `flick[1]` held high → DN1 at 0x001F returns to UP1 repeatedly; `busy` stays 1 and `done` never fires. Releasing `flick[1]` → the next MID point goes to UP2.
- `step_div=3` → `cnt` changes exactly every 4 cycles. Toggle `enable` low for 10 cycles mid-UP2 → `lamps` frozen, and the step phase resumes without loss.
- `flick[0]` high at the DN2 zero point → UP2 re-entered from 0x0000, not UP3.
- `rst_n` low while in UP2 with `lamps=0x00FF` → outputs go to 0 asynchronously; after release the block stays in IDLE until `flick[0]`.
- `LAMP_FLICK_LATCH_EN`, `step_div=15`, a 1-cycle `flick[1]` pulse during DN1 → UP1 is re-entered at MID. Without the macro, the same stimulus → UP2.
